pfa_seq_adder: RTL and testbench
================================

# pfa_seq_adder

Parametrised, multi-cycle carry-lookahead adder/subtractor built from the team's partial-full-adder cell (per-bit s = a^b^c, g = a&b, p = a|b). It resolves one GROUP-bit lookahead slice per clock and ripples the group carry through a carry register between slices. It also returns whole-word propagate/generate, carry-out and signed overflow. It sits beside the datapath as a low-area arithmetic unit driven by a start/done handshake.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of GROUP.
- GROUP, 4, bits resolved per cycle with 4-bit-style lookahead; NG = WIDTH/GROUP slices.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only when idle (busy=0).
- sub  in  1  0 = add, 1 = subtract; latched with the operands.
- a  in  WIDTH  operand A; latched on accept.
- b  in  WIDTH  operand B; latched on accept.
- cin  in  1  carry-in for add; ignored when sub=1.
- busy  out  1  high while slices are being computed.
- done  out  1  one-cycle pulse when results are valid.
- s  out  WIDTH  sum/difference, registered.
- c  out  1  carry-out of the MSB; for subtract, 1 = no borrow.
- p  out  1  word propagate = AND of all per-bit p_i.
- g  out  1  word generate = lookahead-combined G over all groups, independent of cin.
- v  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN. Slice counter k is ceil(log2 NG) bits wide, minimum 1.
- **IDLE**, start=1 at an edge (accept):
  - Latch A=a and B=(sub ? ~b : b).
  - Carry register cr = (sub ? 1 : cin).
  - Set k=0, Pacc=1, Gacc=0.
  - Clear s, c, p, g, v to 0.
  - Set busy=1 and go to RUN.
- **RUN**, each edge, for slice k (bits k*GROUP .. k*GROUP+GROUP-1):
  - Per bit: p_i = A_i|B_i, g_i = A_i&B_i.
  - Bit carries use lookahead from cr: c_{i+1} = g_i | p_i&c_i.
  - s_i = A_i^B_i^c_i, written into the slice of s.
  - cr is updated to the slice carry-out.
  - Group Pk = AND p_i; group Gk = lookahead generate of the slice.
  - Pacc &= Pk; Gacc = Gk | Pk&Gacc.
- **Last slice** (k = NG-1):
  - Drive c = final carry, v = c_MSB_in ^ c_out, p = Pacc, g = Gacc.
  - busy=0, done=1 for exactly one cycle, return to IDLE.
  - Otherwise k increments.
- Outputs s/c/p/g/v hold their values until the next accepted start or reset.
- start while busy=1 is ignored; no queueing, and the in-flight operation is unaffected.
- start high in the cycle done=1 is accepted, because the FSM is already IDLE; back-to-back throughput is one op per NG cycles.
- Operand inputs may change freely after accept; only the latched copies are used.
- Reset (rst_n=0 at an edge), including mid-RUN:
  - state=IDLE, k=0, cr=0, A=B=0.
  - busy=0, done=0, s=0, c=0, p=0, g=0, v=0.
  - The in-flight operation is discarded.
- Reset dominates start in the same cycle.

## Timing
- Accept edge E0; slice k is written at edge E(k+1).
- done=1 and results are valid in the cycle after edge E(NG); latency is NG cycles from accept, e.g. 4 cycles for 16/4.
- busy=1 in the cycles following edges E0..E(NG-1).
- busy and done are never high together.
- Critical path per cycle: one GROUP-bit lookahead slice plus Pacc/Gacc update; no full-width ripple.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Add, WIDTH=16, GROUP=4: a=0x1234, b=0x4321, cin=0, sub=0 -> after 4 cycles done pulse with s=0x5555, c=0, v=0; busy high exactly 4 cycles.
- Full carry chain: a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, c=1, p=1, g=1, v=0.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1 -> s=0xFFFE, c=0, v=0; repeat with a=0x0007, b=0x0005 -> s=0x0002, c=1.
- Overflow: a=0x7FFF, b=0x0001 -> s=0x8000, c=0, v=1; a=0x8000, b=0xFFFF -> s=0x7FFF, c=1, v=1.
- Handshake:
  - Assert start again at cycles 1–3 of a run with different operands -> the original result is unchanged.
  - Assert start in the done cycle -> new op accepted, second done exactly 4 cycles later.
- Reset mid-RUN after slice 2 -> next cycle all outputs 0 and busy=0, no done pulse; a fresh op then completes normally.
- Also run the add vector at WIDTH=8/GROUP=2 and WIDTH=32/GROUP=8.

Source files
------------

// File: rtl/pfa_seq_adder_if.sv
// Start/done handshake bundle for the sequential lookahead adder.
// Master drives the request; slave returns the registered results.
interface pfa_seq_adder_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             sub;
   logic             cin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             c;
   logic             p;
   logic             g;
   logic             v;

   modport master (
      output start, sub, cin, a, b,
      input  busy, done, s, c, p, g, v
   );

   modport slave (
      input  start, sub, cin, a, b,
      output busy, done, s, c, p, g, v
   );
endinterface

// File: rtl/pfa_seq_adder.sv
// Multi-cycle adder/subtractor: one GROUP-bit lookahead slice per clock,
// group carry held in a register between slices.
module pfa_seq_adder #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic clk,
   input  logic rst_n,
   pfa_seq_adder_if.slave io
);

   localparam int NG = WIDTH / GROUP;
   localparam int KW = (NG > 1) ? $clog2(NG) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             cr_q, cr_d;
   logic             pacc_q, pacc_d;
   logic             gacc_q, gacc_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             c_q, c_d;
   logic             p_q, p_d;
   logic             g_q, g_d;
   logic             v_q, v_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [GROUP-1:0] sa, sb, pb, gb, sum;
   logic [GROUP:0]   cc;
   logic             pk, gk, last;
   int               base;

   // Slice datapath: per-bit p/g cells and the lookahead carries from cr.
   always_comb begin
      base = int'(k_q) * GROUP;
      sa   = a_q[base +: GROUP];
      sb   = b_q[base +: GROUP];
      pb   = sa | sb;
      gb   = sa & sb;
      cc   = '0;
      sum  = '0;
      gk   = 1'b0;
      cc[0] = cr_q;
      for (int i = 0; i < GROUP; i++) begin
         cc[i+1] = gb[i] | (pb[i] & cc[i]);
         sum[i]  = sa[i] ^ sb[i] ^ cc[i];
         gk      = gb[i] | (pb[i] & gk);
      end
      pk   = &pb;
      last = (k_q == KW'(NG - 1));
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      a_d     = a_q;
      b_d     = b_q;
      cr_d    = cr_q;
      pacc_d  = pacc_q;
      gacc_d  = gacc_q;
      s_d     = s_q;
      c_d     = c_q;
      p_d     = p_q;
      g_d     = g_q;
      v_d     = v_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (io.start) begin
               a_d     = io.a;
               b_d     = io.sub ? ~io.b : io.b;
               cr_d    = io.sub ? 1'b1 : io.cin;
               k_d     = '0;
               pacc_d  = 1'b1;
               gacc_d  = 1'b0;
               s_d     = '0;
               c_d     = 1'b0;
               p_d     = 1'b0;
               g_d     = 1'b0;
               v_d     = 1'b0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            s_d[base +: GROUP] = sum;
            cr_d   = cc[GROUP];
            pacc_d = pacc_q & pk;
            gacc_d = gk | (pk & gacc_q);
            if (last) begin
               c_d     = cc[GROUP];
               v_d     = cc[GROUP-1] ^ cc[GROUP];
               p_d     = pacc_q & pk;
               g_d     = gk | (pk & gacc_q);
               busy_d  = 1'b0;
               done_d  = 1'b1;
               k_d     = '0;
               state_d = IDLE;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cr_q    <= 1'b0;
         pacc_q  <= 1'b0;
         gacc_q  <= 1'b0;
         s_q     <= '0;
         c_q     <= 1'b0;
         p_q     <= 1'b0;
         g_q     <= 1'b0;
         v_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cr_q    <= cr_d;
         pacc_q  <= pacc_d;
         gacc_q  <= gacc_d;
         s_q     <= s_d;
         c_q     <= c_d;
         p_q     <= p_d;
         g_q     <= g_d;
         v_q     <= v_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign io.busy = busy_q;
   assign io.done = done_q;
   assign io.s    = s_q;
   assign io.c    = c_q;
   assign io.p    = p_q;
   assign io.g    = g_q;
   assign io.v    = v_q;

endmodule

// File: tb/tb_pfa_seq_adder.sv
// Bench for pfa_seq_adder at 16/4, 8/2 and 32/8 against an
// arithmetic reference model.
module tb_pfa_seq_adder;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   pfa_seq_adder_if #(.WIDTH(16)) if16 ();
   pfa_seq_adder_if #(.WIDTH(8))  if8  ();
   pfa_seq_adder_if #(.WIDTH(32)) if32 ();

   pfa_seq_adder #(.WIDTH(16), .GROUP(4)) u16 (
      .clk(clk), .rst_n(rst_n), .io(if16)
   );
   pfa_seq_adder #(.WIDTH(8), .GROUP(2)) u8 (
      .clk(clk), .rst_n(rst_n), .io(if8)
   );
   pfa_seq_adder #(.WIDTH(32), .GROUP(8)) u32 (
      .clk(clk), .rst_n(rst_n), .io(if32)
   );

   // Reference: plain integer arithmetic on a w-bit word.
   function automatic void model(
      input int w, input logic [63:0] a, input logic [63:0] b,
      input logic sub, input logic cin,
      output logic [63:0] s, output logic c, output logic p,
      output logic g, output logic v);
      logic [63:0] mask, m1, aa, bb, sum, lo, raw;
      logic        c0;
      mask = (64'd1 << w) - 64'd1;
      m1   = mask >> 1;
      aa   = a & mask;
      bb   = (sub ? ~b : b) & mask;
      c0   = sub ? 1'b1 : cin;
      sum  = aa + bb + 64'(c0);
      s    = sum & mask;
      c    = sum[w];
      lo   = (aa & m1) + (bb & m1) + 64'(c0);
      v    = lo[w-1] ^ c;
      p    = (((aa | bb) & mask) == mask);
      raw  = aa + bb;
      g    = raw[w];
   endfunction

   task automatic go16(input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic cin);
      if16.a     = a;
      if16.b     = b;
      if16.sub   = sub;
      if16.cin   = cin;
      if16.start = 1'b1;
      @(posedge clk); #1;
      if16.start = 1'b0;
      if16.a     = 16'($urandom);
      if16.b     = 16'($urandom);
      if16.sub   = 1'($urandom);
      if16.cin   = 1'($urandom);
   endtask

   task automatic wait16(output int cyc, output int bc, output int both);
      cyc  = 0;
      bc   = 0;
      both = 0;
      while (!if16.done && cyc < 20) begin
         if (if16.busy) bc++;
         @(posedge clk); #1;
         cyc++;
         if (if16.busy && if16.done) both++;
      end
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      if16.start = 1'b1;
      if16.a     = 16'h1234;
      if16.b     = 16'h4321;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({if16.busy, if16.done, if16.s, if16.c, if16.p, if16.g, if16.v}
          !== 22'd0) begin
         n_err++;
         $display("FAIL reset16: busy=%b done=%b s=%h c%b p%b g%b v%b want all 0",
                  if16.busy, if16.done, if16.s, if16.c, if16.p, if16.g, if16.v);
      end
      n_cmp++;
      if ({if8.busy, if8.done, if8.s, if32.busy, if32.done, if32.s} !== 44'd0) begin
         n_err++;
         $display("FAIL reset_w: s8=%h s32=%h busy=%b%b want 0",
                  if8.s, if32.s, if8.busy, if32.busy);
      end
      if16.start = 1'b0;
      rst_n      = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (if16.busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_dom: busy=%b want 0", if16.busy);
      end
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic        cin;
      logic [15:0] es;
      logic        ec;
      logic        ev;
   } vec_t;

   task automatic test_directed();
      vec_t vt [7];
      logic [63:0] ms;
      logic mc, mp, mg, mv;
      int cyc, bc, both;
      vt[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
      vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[2] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
      vt[3] = '{16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0};
      vt[4] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
      vt[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vt[6] = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      foreach (vt[i]) begin
         model(16, 64'(vt[i].a), 64'(vt[i].b), vt[i].sub, vt[i].cin,
               ms, mc, mp, mg, mv);
         go16(vt[i].a, vt[i].b, vt[i].sub, vt[i].cin);
         wait16(cyc, bc, both);
         n_cmp++;
         if ({if16.done, if16.s, if16.c, if16.v} !==
             {1'b1, vt[i].es, vt[i].ec, vt[i].ev}) begin
            n_err++;
            $display("FAIL vec%0d: done=%b s=%h c=%b v=%b want s=%h c=%b v=%b",
                     i, if16.done, if16.s, if16.c, if16.v,
                     vt[i].es, vt[i].ec, vt[i].ev);
         end
         n_cmp++;
         if ({if16.p, if16.g} !== {mp, mg}) begin
            n_err++;
            $display("FAIL vec%0d_pg: p=%b g=%b want p=%b g=%b",
                     i, if16.p, if16.g, mp, mg);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timing();
      int cyc, bc, both;
      go16(16'h1234, 16'h4321, 1'b0, 1'b0);
      wait16(cyc, bc, both);
      n_cmp++;
      if (cyc !== 4 || bc !== 4 || both !== 0) begin
         n_err++;
         $display("FAIL timing: latency=%0d busy_cycles=%0d overlap=%0d want 4/4/0",
                  cyc, bc, both);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({if16.done, if16.busy} !== 2'b00) begin
         n_err++;
         $display("FAIL done_pulse: done=%b busy=%b want 0 0",
                  if16.done, if16.busy);
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({if16.s, if16.c, if16.v} !== {16'h5555, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL hold: s=%h c=%b v=%b want 5555 0 0",
                  if16.s, if16.c, if16.v);
      end
   endtask

   task automatic test_random();
      logic [15:0] a, b;
      logic sub, cin;
      logic [63:0] ms;
      logic mc, mp, mg, mv;
      int cyc, bc, both;
      for (int i = 0; i < 40; i++) begin
         a   = 16'($urandom);
         b   = 16'($urandom);
         sub = 1'($urandom);
         cin = 1'($urandom);
         if (i % 8 == 0) b = ~a;
         model(16, 64'(a), 64'(b), sub, cin, ms, mc, mp, mg, mv);
         go16(a, b, sub, cin);
         wait16(cyc, bc, both);
         n_cmp++;
         if ({if16.done, if16.s, if16.c, if16.p, if16.g, if16.v} !==
             {1'b1, ms[15:0], mc, mp, mg, mv}) begin
            n_err++;
            $display("FAIL rand%0d: a=%h b=%h sub=%b cin=%b got s=%h c%b p%b g%b v%b want s=%h c%b p%b g%b v%b",
                     i, a, b, sub, cin, if16.s, if16.c, if16.p, if16.g, if16.v,
                     ms[15:0], mc, mp, mg, mv);
         end
      end
   endtask

   task automatic test_busy_start();
      logic [63:0] ms;
      logic mc, mp, mg, mv;
      int cyc, bc, both;
      model(16, 64'h1234, 64'h4321, 1'b0, 1'b1, ms, mc, mp, mg, mv);
      go16(16'h1234, 16'h4321, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         if16.start = 1'b1;
         if16.a     = 16'hFFFF;
         if16.b     = 16'($urandom);
         if16.sub   = 1'b1;
         @(posedge clk); #1;
      end
      if16.start = 1'b0;
      wait16(cyc, bc, both);
      n_cmp++;
      if (cyc !== 1 || {if16.s, if16.c, if16.v} !== {ms[15:0], mc, mv}) begin
         n_err++;
         $display("FAIL busy_start: cyc=%0d s=%h c=%b v=%b want cyc=1 s=%h c=%b v=%b",
                  cyc, if16.s, if16.c, if16.v, ms[15:0], mc, mv);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (if16.busy !== 1'b0) begin
         n_err++;
         $display("FAIL busy_start_q: busy=%b want 0", if16.busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] ms;
      logic mc, mp, mg, mv;
      int cyc, bc, both;
      go16(16'h00F0, 16'h0F10, 1'b0, 1'b0);
      wait16(cyc, bc, both);
      n_cmp++;
      if (if16.s !== 16'h1000) begin
         n_err++;
         $display("FAIL b2b_first: s=%h want 1000", if16.s);
      end
      model(16, 64'h9ABC, 64'h1357, 1'b1, 1'b0, ms, mc, mp, mg, mv);
      go16(16'h9ABC, 16'h1357, 1'b1, 1'b0);
      n_cmp++;
      if ({if16.busy, if16.done} !== 2'b10) begin
         n_err++;
         $display("FAIL b2b_accept: busy=%b done=%b want 1 0",
                  if16.busy, if16.done);
      end
      wait16(cyc, bc, both);
      n_cmp++;
      if (cyc !== 4 || {if16.s, if16.c, if16.p, if16.g, if16.v} !==
          {ms[15:0], mc, mp, mg, mv}) begin
         n_err++;
         $display("FAIL b2b_second: cyc=%0d s=%h c=%b want cyc=4 s=%h c=%b",
                  cyc, if16.s, if16.c, ms[15:0], mc);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      logic [63:0] ms;
      logic mc, mp, mg, mv;
      int cyc, bc, both;
      int seen;
      go16(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if ({if16.busy, if16.done, if16.s, if16.c, if16.p, if16.g, if16.v}
          !== 22'd0) begin
         n_err++;
         $display("FAIL reset_mid: busy=%b done=%b s=%h c%b p%b g%b v%b want all 0",
                  if16.busy, if16.done, if16.s, if16.c, if16.p, if16.g, if16.v);
      end
      rst_n = 1'b1;
      seen  = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (if16.done || if16.busy) seen++;
      end
      n_cmp++;
      if (seen !== 0) begin
         n_err++;
         $display("FAIL reset_nodone: activity=%0d want 0", seen);
      end
      model(16, 64'h0F0F, 64'h7777, 1'b0, 1'b1, ms, mc, mp, mg, mv);
      go16(16'h0F0F, 16'h7777, 1'b0, 1'b1);
      wait16(cyc, bc, both);
      n_cmp++;
      if (cyc !== 4 || {if16.s, if16.c, if16.p, if16.g, if16.v} !==
          {ms[15:0], mc, mp, mg, mv}) begin
         n_err++;
         $display("FAIL reset_fresh: cyc=%0d s=%h want cyc=4 s=%h",
                  cyc, if16.s, ms[15:0]);
      end
   endtask

   task automatic test_widths();
      logic [63:0] a8, b8, a32, b32, s8, s32;
      logic sub, cin;
      logic c8, p8, g8, v8, c32, p32, g32, v32;
      int cyc;
      for (int i = 0; i < 8; i++) begin
         if (i == 0) begin
            a8 = 64'h34; b8 = 64'h21; a32 = 64'h1234; b32 = 64'h4321;
            sub = 1'b0; cin = 1'b0;
         end else begin
            a8  = 64'($urandom_range(255));
            b8  = 64'($urandom_range(255));
            a32 = 64'($urandom);
            b32 = 64'($urandom);
            sub = 1'($urandom);
            cin = 1'($urandom);
         end
         model(8, a8, b8, sub, cin, s8, c8, p8, g8, v8);
         model(32, a32, b32, sub, cin, s32, c32, p32, g32, v32);
         if8.a  = a8[7:0];   if8.b  = b8[7:0];
         if32.a = a32[31:0]; if32.b = b32[31:0];
         if8.sub = sub; if8.cin = cin; if32.sub = sub; if32.cin = cin;
         if8.start = 1'b1; if32.start = 1'b1;
         @(posedge clk); #1;
         if8.start = 1'b0; if32.start = 1'b0;
         cyc = 0;
         while (!(if8.done && if32.done) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
         end
         n_cmp++;
         if (cyc !== 4 || {if8.s, if8.c, if8.p, if8.g, if8.v} !==
             {s8[7:0], c8, p8, g8, v8}) begin
            n_err++;
            $display("FAIL w8_%0d: cyc=%0d s=%h c%b p%b g%b v%b want s=%h c%b p%b g%b v%b",
                     i, cyc, if8.s, if8.c, if8.p, if8.g, if8.v,
                     s8[7:0], c8, p8, g8, v8);
         end
         n_cmp++;
         if ({if32.s, if32.c, if32.p, if32.g, if32.v} !==
             {s32[31:0], c32, p32, g32, v32}) begin
            n_err++;
            $display("FAIL w32_%0d: s=%h c%b p%b g%b v%b want s=%h c%b p%b g%b v%b",
                     i, if32.s, if32.c, if32.p, if32.g, if32.v,
                     s32[31:0], c32, p32, g32, v32);
         end
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      if16.start = 1'b0; if16.sub = 1'b0; if16.cin = 1'b0;
      if16.a     = '0;   if16.b   = '0;
      if8.start  = 1'b0; if8.sub  = 1'b0; if8.cin  = 1'b0;
      if8.a      = '0;   if8.b    = '0;
      if32.start = 1'b0; if32.sub = 1'b0; if32.cin = 1'b0;
      if32.a     = '0;   if32.b   = '0;
      test_reset();
      test_directed();
      test_timing();
      test_random();
      test_busy_start();
      test_back_to_back();
      test_reset_mid();
      test_widths();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
